// File: rtl/conv_ctrl_pkg.sv
// Shared types and derived-size helpers for the convolution MAC controller.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_FINISH
  } state_t;

  // Bit width for a counter or address covering n values; never below 1.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ow_f(input int img_w, input int k);
    return img_w - k + 1;
  endfunction

  function automatic int oh_f(input int img_h, input int k);
    return img_h - k + 1;
  endfunction

  function automatic int n_taps_f(input int k, input int ch_in);
    return k * k * ch_in;
  endfunction

  function automatic int p_pix_f(input int img_w, input int img_h, input int k);
    return ow_f(img_w, k) * oh_f(img_h, k);
  endfunction

endpackage

// File: rtl/conv_mac_controller_p_mac.sv
// Signed multiply-accumulate; load restarts the sum with the current product.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);

  // Sum wraps modulo 2^ACC_W by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= load ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/conv_mac_controller_p.sv
// KxK stride-1 convolution sequencer over BRAM-backed image/weights.
// Optional macro CONV_RELU_EN clamps negative results to zero at the output.
module conv_mac_controller_p
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3,
  parameter int CH_IN  = 1,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic [clog2w(CH_IN*IMG_H*IMG_W)-1:0]         img_address,
  output logic                                         img_data_ena,
  input  logic [DATA_W-1:0]                            img_data,
  output logic [clog2w(CH_IN*K*K)-1:0]                 weight_address,
  output logic                                         weight_data_ena,
  input  logic [DATA_W-1:0]                            weight_data,
  output logic [clog2w(p_pix_f(IMG_W, IMG_H, K))-1:0]  out_address,
  output logic [ACC_W-1:0]                             out_data,
  output logic                                         data_validity,
  input  logic                                         out_ready,
  output logic                                         busy,
  output logic                                         done,
  output state_t                                       dbg_state
);

  localparam int OW   = ow_f(IMG_W, K);
  localparam int OH   = oh_f(IMG_H, K);
  localparam int IA_W = clog2w(CH_IN*IMG_H*IMG_W);
  localparam int WA_W = clog2w(CH_IN*K*K);
  localparam int OA_W = clog2w(p_pix_f(IMG_W, IMG_H, K));
  localparam int OXW  = clog2w(OW);
  localparam int OYW  = clog2w(OH);
  localparam int KW   = clog2w(K);
  localparam int CW   = clog2w(CH_IN);

  if (ACC_W < 2*DATA_W) begin : g_acc_width_check
    $error("ACC_W must be at least 2*DATA_W");
  end
  if (K > IMG_W || K > IMG_H) begin : g_kernel_check
    $error("kernel larger than image");
  end

  state_t state, state_nx;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;
  logic [CW-1:0]  c;
  logic [KW-1:0]  ky, kx;
  logic           tap_vld, tap_first;
  logic           first_tap, last_tap, last_pix;
  logic [31:0]    img_addr_full, w_addr_full, out_addr_full;
  logic signed [ACC_W-1:0] acc;
  logic           mac_load, mac_en, idle;
  logic [DATA_W-1:0] mac_a, mac_b;

  assign idle      = (state == S_IDLE);
  assign first_tap = (kx == '0) && (ky == '0) && (c == '0);
  assign last_tap  = (kx == KW'(K-1)) && (ky == KW'(K-1)) && (c == CW'(CH_IN-1));
  assign last_pix  = (ox == OXW'(OW-1)) && (oy == OYW'(OH-1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  if (last_tap) state_nx = S_DRAIN;
      S_DRAIN:  state_nx = S_WRITE;
      S_WRITE:  if (out_ready) state_nx = last_pix ? S_FINISH : S_FETCH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ox        <= '0;
      oy        <= '0;
      c         <= '0;
      ky        <= '0;
      kx        <= '0;
      tap_vld   <= 1'b0;
      tap_first <= 1'b0;
    end else begin
      state     <= state_nx;
      // Data for a read issued this cycle arrives next cycle; tag it then.
      tap_vld   <= (state == S_FETCH);
      tap_first <= (state == S_FETCH) && first_tap;
      case (state)
        S_IDLE: begin
          ox <= '0;
          oy <= '0;
          c  <= '0;
          ky <= '0;
          kx <= '0;
        end
        S_FETCH: begin
          if (kx == KW'(K-1)) begin
            kx <= '0;
            if (ky == KW'(K-1)) begin
              ky <= '0;
              c  <= (c == CW'(CH_IN-1)) ? '0 : c + CW'(1);
            end else begin
              ky <= ky + KW'(1);
            end
          end else begin
            kx <= kx + KW'(1);
          end
        end
        S_WRITE: begin
          if (out_ready) begin
            if (ox == OXW'(OW-1)) begin
              ox <= '0;
              oy <= (oy == OYW'(OH-1)) ? '0 : oy + OYW'(1);
            end else begin
              ox <= ox + OXW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign img_addr_full = 32'(c) * 32'(IMG_H*IMG_W) + (32'(oy) + 32'(ky)) * 32'(IMG_W)
                       + 32'(ox) + 32'(kx);
  assign w_addr_full   = 32'(c) * 32'(K*K) + 32'(ky) * 32'(K) + 32'(kx);
  assign out_addr_full = 32'(oy) * 32'(OW) + 32'(ox);

  assign img_address     = img_addr_full[IA_W-1:0];
  assign weight_address  = w_addr_full[WA_W-1:0];
  assign out_address     = out_addr_full[OA_W-1:0];
  assign img_data_ena    = (state == S_FETCH);
  assign weight_data_ena = (state == S_FETCH);
  assign data_validity   = (state == S_WRITE);
  assign busy            = !idle;
  assign done            = (state == S_FINISH);
  assign dbg_state       = state;

  // While idle, a zero product is loaded so the accumulator clears.
  assign mac_load = tap_first || idle;
  assign mac_en   = tap_vld || idle;
  assign mac_a    = idle ? '0 : img_data;
  assign mac_b    = idle ? '0 : weight_data;

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mac_load),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc)
  );

`ifdef CONV_RELU_EN
  assign out_data = acc[ACC_W-1] ? '0 : acc;
`else
  assign out_data = acc;
`endif

endmodule

// File: tb/tb_conv_mac_controller_p.sv
// Bench for conv_mac_controller_p: default 32x32 instance plus an 8x8 two-channel instance.
module tb_conv_mac_controller_p;
  import conv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default instance
  logic        start = 1'b0;
  logic [9:0]  img_address;
  logic        img_data_ena;
  logic [7:0]  img_data;
  logic [3:0]  weight_address;
  logic        weight_data_ena;
  logic [7:0]  weight_data;
  logic [9:0]  out_address;
  logic [23:0] out_data;
  logic        data_validity;
  logic        out_ready = 1'b1;
  logic        busy, done;
  state_t      dbg_state;
  logic [7:0]  img_mem [0:1023];
  logic [7:0]  w_mem [0:8];

  // Two-channel 8x8 instance
  logic        start2 = 1'b0;
  logic [6:0]  img2_address;
  logic        img2_ena;
  logic [7:0]  img2_data;
  logic [4:0]  w2_address;
  logic        w2_ena;
  logic [7:0]  w2_data;
  logic [5:0]  out2_address;
  logic [23:0] out2_data;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic        busy2, done2;
  state_t      dbg_state2;
  logic [7:0]  img2_mem [0:127];
  logic [7:0]  w2_mem [0:17];

  logic [23:0] exp_q[$];
  logic [9:0]  exp_a_q[$];
  logic [23:0] exp2_q[$];
  logic [5:0]  exp2_a_q[$];

  conv_mac_controller_p dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_address(img_address), .img_data_ena(img_data_ena), .img_data(img_data),
    .weight_address(weight_address), .weight_data_ena(weight_data_ena), .weight_data(weight_data),
    .out_address(out_address), .out_data(out_data), .data_validity(data_validity),
    .out_ready(out_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  conv_mac_controller_p #(.IMG_W(8), .IMG_H(8), .K(3), .CH_IN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .img_address(img2_address), .img_data_ena(img2_ena), .img_data(img2_data),
    .weight_address(w2_address), .weight_data_ena(w2_ena), .weight_data(w2_data),
    .out_address(out2_address), .out_data(out2_data), .data_validity(valid2),
    .out_ready(ready2), .busy(busy2), .done(done2), .dbg_state(dbg_state2)
  );

  // BRAM models, one-cycle read latency
  always @(posedge clk) begin
    if (img_data_ena) img_data <= img_mem[img_address];
    if (weight_data_ena) weight_data <= w_mem[weight_address];
    if (img2_ena) img2_data <= img2_mem[img2_address];
    if (w2_ena) w2_data <= w2_mem[w2_address];
  end

  // Scoreboard monitors: pop on every accepted result
  always @(negedge clk) begin
    if (rst_n && data_validity && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected addr=%0d data=%h", out_address, out_data);
      end else begin
        logic [23:0] ed;
        logic [9:0]  ea;
        ed = exp_q.pop_front();
        ea = exp_a_q.pop_front();
        if (out_data !== ed || out_address !== ea) begin
          errors++;
          $display("FAIL out_result addr=%0d data=%h expected addr=%0d data=%h",
                   out_address, out_data, ea, ed);
        end
      end
    end
    if (rst_n && valid2 && ready2) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL out2_unexpected addr=%0d data=%h", out2_address, out2_data);
      end else begin
        logic [23:0] ed;
        logic [5:0]  ea;
        ed = exp2_q.pop_front();
        ea = exp2_a_q.pop_front();
        if (out2_data !== ed || out2_address !== ea) begin
          errors++;
          $display("FAIL out2_result addr=%0d data=%h expected addr=%0d data=%h",
                   out2_address, out2_data, ea, ed);
        end
      end
    end
  end

  function automatic logic [23:0] ref_pix(input int oy, input int ox);
    int s;
    logic [23:0] r;
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += int'($signed(img_mem[(oy+ky)*32 + ox + kx])) * int'($signed(w_mem[ky*3 + kx]));
    r = s[23:0];
`ifdef CONV_RELU_EN
    if (r[23]) r = '0;
`endif
    return r;
  endfunction

  task automatic fill_const(input logic [7:0] iv, input logic [7:0] wv);
    for (int i = 0; i < 1024; i++) img_mem[i] = iv;
    for (int i = 0; i < 9; i++) w_mem[i] = wv;
  endtask

  task automatic push_const(input logic [23:0] v);
    exp_q.delete();
    exp_a_q.delete();
    for (int p = 0; p < 900; p++) begin
      exp_q.push_back(v);
      exp_a_q.push_back(10'(p));
    end
  endtask

  // Pulse start; returns the cycle index (start cycle = 0) of done, or -1.
  task automatic start_and_wait(output int n);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    while (!done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (out_address !== 10'd0 || out_data !== 24'd0 || data_validity !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || img_data_ena !== 1'b0 || weight_data_ena !== 1'b0 ||
        img_address !== 10'd0 || weight_address !== 4'd0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_outputs addr=%0d data=%h valid=%b busy=%b done=%b ena=%b/%b required all zero",
               out_address, out_data, data_validity, busy, done, img_data_ena, weight_data_ena);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_all_ones;
    int n;
    fill_const(8'd1, 8'd1);
    push_const(24'd9);
    start_and_wait(n);
    checks++;
    if (n !== 9901) begin
      errors++;
      $display("FAIL ones_done_cycle got=%0d required=9901", n);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() !== 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ones_end left=%0d busy=%b done=%b required 0/0/0", exp_q.size(), busy, done);
    end
  endtask

  task automatic test_ramp;
    int n;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) img_mem[y*32 + x] = 8'(x);
    for (int i = 0; i < 9; i++) w_mem[i] = 8'd0;
    w_mem[1*3 + 2] = 8'd1;
    exp_q.delete();
    exp_a_q.delete();
    for (int oy = 0; oy < 30; oy++)
      for (int ox = 0; ox < 30; ox++) begin
        exp_q.push_back(24'(ox + 2));
        exp_a_q.push_back(10'(oy*30 + ox));
      end
    start_and_wait(n);
    checks++;
    if (n !== 9901 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL ramp_frame done_cycle=%0d left=%0d required 9901/0", n, exp_q.size());
    end
  endtask

  task automatic test_negative;
    int n;
    fill_const(8'd100, 8'hFF);
`ifdef CONV_RELU_EN
    push_const(24'h000000);
`else
    push_const(24'hFFFC7C);
`endif
    start_and_wait(n);
    checks++;
    if (n !== 9901 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL negative_frame done_cycle=%0d left=%0d required 9901/0", n, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [23:0] d0;
    for (int i = 0; i < 1024; i++) img_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++) w_mem[i] = 8'($urandom_range(0, 255));
    exp_q.delete();
    exp_a_q.delete();
    for (int oy = 0; oy < 30; oy++)
      for (int ox = 0; ox < 30; ox++) begin
        exp_q.push_back(ref_pix(oy, ox));
        exp_a_q.push_back(10'(oy*30 + ox));
      end
    out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    while (!data_validity && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 11) begin
      errors++;
      $display("FAIL bp_first_write cycle=%0d required=11", n);
    end
    d0 = out_data;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_validity !== 1'b1 || out_address !== 10'd0 || out_data !== d0 ||
          img_data_ena !== 1'b0 || weight_data_ena !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold valid=%b addr=%0d data=%h ena=%b/%b required 1/0/%h/0/0",
                 data_validity, out_address, out_data, img_data_ena, weight_data_ena, d0);
      end
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n++;
    checks++;
    if (img_data_ena !== 1'b1 || weight_data_ena !== 1'b1 || img_address !== 10'd1 ||
        weight_address !== 4'd0) begin
      errors++;
      $display("FAIL bp_resume ena=%b/%b img_addr=%0d w_addr=%0d required 1/1/1/0",
               img_data_ena, weight_data_ena, img_address, weight_address);
    end
    while (!done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 9906 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_frame done_cycle=%0d left=%0d required 9906/0", n, exp_q.size());
    end
  endtask

  task automatic test_multichannel;
    int n;
    int first_w;
    for (int i = 0; i < 64; i++) img2_mem[i] = 8'd1;
    for (int i = 64; i < 128; i++) img2_mem[i] = 8'd2;
    for (int i = 0; i < 18; i++) w2_mem[i] = 8'd1;
    for (int p = 0; p < 36; p++) begin
      exp2_q.push_back(24'd27);
      exp2_a_q.push_back(6'(p));
    end
    first_w = -1;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    n = 1;
    while (!done2 && n < 2000) begin
      if (valid2 && first_w < 0) first_w = n;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (first_w !== 20 || n !== 721 || exp2_q.size() !== 0) begin
      errors++;
      $display("FAIL multich_frame first_write=%0d done_cycle=%0d left=%0d required 20/721/0",
               first_w, n, exp2_q.size());
    end
  endtask

  task automatic test_control;
    int n;
    fill_const(8'd1, 8'd1);
    push_const(24'd9);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    while (!(data_validity && out_address == 10'd100) && n < 2000) begin
      start = (n == 50);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (n !== 1111 || exp_q.size() !== 800) begin
      errors++;
      $display("FAIL ctrl_mid_start pixel100_cycle=%0d left=%0d required 1111/800", n, exp_q.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_address !== 10'd0 || out_data !== 24'd0 || data_validity !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || img_data_ena !== 1'b0 || weight_data_ena !== 1'b0 || img_address !== 10'd0) begin
      errors++;
      $display("FAIL ctrl_async_reset addr=%0d data=%h valid=%b busy=%b done=%b required all zero",
               out_address, out_data, data_validity, busy, done);
    end
    exp_q.delete();
    exp_a_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ctrl_reset_hold done=%b busy=%b required 0/0", done, busy);
      end
    end
    rst_n = 1'b1;
    push_const(24'd9);
    start_and_wait(n);
    checks++;
    if (n !== 9901 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL ctrl_restart done_cycle=%0d left=%0d required 9901/0", n, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_ramp();
    test_negative();
    test_backpressure();
    test_multichannel();
    test_control();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_mac_controller_p.md
Name: conv_mac_controller_p

Overview:
- Parametrised successor to queue_mac_controller.
- Sequences a KxK, stride-1, no-padding convolution over an IMG_H x IMG_W image with CH_IN input channels.
- Reads image and weight BRAMs (1-cycle read latency), accumulates in a signed MAC, and emits one result per output pixel to output_data_controller through a valid/ready handshake.
- Sits between the img/weight BRAM ports and the output writer under top-level start control.

Parameters:
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in pixels
- K, 3, kernel side length
- CH_IN, 1, input channels summed into each output
- DATA_W, 8, signed pixel/weight width
- ACC_W, 24, accumulator/output width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; launches one full frame when idle
- img_address  out  $clog2(CH_IN*IMG_H*IMG_W)  image BRAM address = c*IMG_H*IMG_W + (oy+ky)*IMG_W + (ox+kx)
- img_data_ena  out  1  image BRAM read enable
- img_data  in  DATA_W  image BRAM data, valid 1 cycle after enable
- weight_address  out  $clog2(CH_IN*K*K)  = c*K*K + ky*K + kx
- weight_data_ena  out  1  weight BRAM read enable
- weight_data  in  DATA_W  weight BRAM data, 1-cycle latency
- out_address  out  $clog2(OH*OW)  = oy*OW + ox, where OW=IMG_W-K+1 and OH=IMG_H-K+1
- out_data  out  ACC_W  convolution result
- data_validity  out  1  result valid
- out_ready  in  1  downstream accepts result
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all outputs and counters 0; accumulator 0.
- FSM states: IDLE, FETCH, DRAIN, WRITE, FINISH.
- IDLE:
  - start=1 → FETCH next cycle.
  - ox, oy, c, ky, kx are cleared.
  - Accumulator is cleared.
- FETCH:
  - One read per cycle; img_data_ena and weight_data_ena both high.
  - Loop order, innermost first: kx, ky, c.
  - After N=K*K*CH_IN reads → DRAIN.
- Pipeline:
  - A read issued in cycle t returns in cycle t+1.
  - That data is accumulated at the end of cycle t+1 via a tap-valid flag delayed by one cycle.
  - The first tap of each pixel loads the accumulator rather than adding to it.
- DRAIN: one cycle, enables low, last tap accumulates → WRITE.
- WRITE:
  - data_validity=1; out_data=acc; out_address=current pixel.
  - Address and data are held stable while out_ready=0.
  - On out_ready=1: advance ox, wrapping at OW and incrementing oy.
  - If this was the last pixel → FINISH; otherwise → FETCH next cycle.
- FINISH: done=1 for one cycle → IDLE. busy is low in IDLE.
- Arithmetic:
  - DATA_W x DATA_W signed product (2*DATA_W bits), sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W, with no saturation.
- Timing with out_ready held high:
  - start sampled in cycle 0; fetches in cycles 1..N; WRITE in cycle N+2.
  - Per-pixel period is N+2 cycles.
  - done appears in cycle P*(N+2)+1, where P=OH*OW.
  - Defaults: N=9, P=900, so done appears in cycle 9901.
- start while not IDLE is ignored.
- rst_n asserted mid-frame aborts the frame immediately, with no done pulse.
- Parameter legality: K ≤ IMG_W and K ≤ IMG_H. ACC_W ≥ 2*DATA_W; this is checked by an elaboration-time assertion.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: out_data = 0 when acc is negative, otherwise acc. Applied combinationally at the output only; address and handshake are unchanged.
- Undefined: out_data = raw acc, signed two's complement.

Decomposition:
- Package conv_ctrl_pkg:
  - FSM state enum.
  - clog2-based width helper.
  - Derived constants OW, OH, N_TAPS, P_PIX as parameterised functions.
- Sub-module mac_unit (DATA_W, ACC_W):
  - Inputs: clk, rst_n, load, en, a, b. Output: acc.
  - Signed multiply-accumulate.
- Controller keeps FSM, counters and address generation.

Test Plan:
- All-ones test:
  - Stimulus: defaults; image all 1, weights all 1; out_ready=1.
  - Response: 900 results all equal 9; addresses 0..899 in order; done in cycle 9901 after start.
- Ramp test:
  - Stimulus: image value = x (0..31 per row); weight (ky=1,kx=2)=1, all other weights 0.
  - Response: out_data = ox+2 for every pixel.
- Negative accumulation:
  - Stimulus: weights all -1, image all 100.
  - Response without CONV_RELU_EN: out_data = 0xFFFC7C (-900). With CONV_RELU_EN: 0.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles on pixel 0.
  - Response: data_validity, address 0 and data held stable; no BRAM enables during the hold; pixel 1 fetch starts the cycle after ready rises.
- Multi-channel:
  - Stimulus: CH_IN=2, IMG 8x8, K=3; channel 0 all 1, channel 1 all 2; weights all 1.
  - Response: 36 results of 27; per-pixel period 20 cycles.
- Control robustness:
  - Stimulus: start pulsed mid-frame; rst_n low at pixel 100; then a fresh start.
  - Response: mid-frame start ignored; reset zeroes all outputs asynchronously with no done pulse; restarted frame completes normally from address 0.
